// File: rtl/sync_fifo_gen.sv
// Parametrised single-clock FIFO for any depth >= 2, including non-power-of-2 depths.
// Provides an occupancy count, registered write/overflow/underflow status and an optional FWFT read port.
module sync_fifo_gen #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    parameter int FWFT       = 0,
    localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic [CW-1:0]         count,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    generate
        if (!(FIFO_WIDTH >= 1 && FIFO_DEPTH >= 2 && AE_LEVEL >= 1 &&
              AE_LEVEL < AF_LEVEL && AF_LEVEL <= FIFO_DEPTH - 1)) begin : g_param_err
            $error("sync_fifo_gen: illegal FIFO_WIDTH/FIFO_DEPTH/AE_LEVEL/AF_LEVEL combination");
        end
    endgenerate

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_ack_q, wr_ack_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_accept, rd_accept;

    // All flags decode the registered count, so no input reaches an output combinationally.
    assign full        = (count_q == CW'(FIFO_DEPTH));
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= CW'(AF_LEVEL)) && (count_q < CW'(FIFO_DEPTH));
    assign almostempty = (count_q != '0) && (count_q <= CW'(AE_LEVEL));

    assign count     = count_q;
    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    always_comb begin
        // A write into a full FIFO is allowed when the same edge pops a word.
        wr_accept = wr_en && (!full || rd_en);
        rd_accept = rd_en && !empty;

        wr_ptr_d = wr_ptr_q;
        if (wr_accept) begin
            wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (rd_accept) begin
            rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end

        count_d = count_q;
        if (wr_accept && !rd_accept) begin
            count_d = count_q + CW'(1);
        end else if (rd_accept && !wr_accept) begin
            count_d = count_q - CW'(1);
        end

        wr_ack_d    = wr_accept;
        overflow_d  = wr_en && !wr_accept;
        underflow_d = rd_en && !rd_accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never cleared; reset only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = mem[rd_ptr_q];
        end else begin : g_reg_read
            logic [FIFO_WIDTH-1:0] dout_q, dout_d;

            always_comb begin
                dout_d = dout_q;
                if (rd_accept) begin
                    dout_d = mem[rd_ptr_q];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q <= '0;
                end else begin
                    dout_q <= dout_d;
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

endmodule
